uart_led_cmd_ctrl: RTL and testbench
====================================

// Module: uart_led_cmd_ctrl
// PURPOSE
//  Command sequencer between uart_rx and the RGB LED driver. Consumes received bytes
//  (data + one-cycle done strobe), assembles 4-byte frames, validates header/checksum,
//  and updates three 8-bit colour duty registers. Replaces the single-byte data_buf
//  path in top. Provides per-frame status strobes and a saturating error counter.
// PARAMETERS
//  CLOCK_FREQ      12000000  system clock in Hz (documentation/derivation only)
//  TIMEOUT_CYCLES  24000     max idle clks between bytes inside a frame (2 ms at 12 MHz)
//  CNT_W           15        width of inter-byte timer; must hold TIMEOUT_CYCLES
// PORTS
//  clk         in   1  system clock, all logic on posedge
//  rst_n       in   1  synchronous active-low reset
//  rx_data     in   8  byte from uart_rx, valid only when rx_done=1
//  rx_done     in   1  one-cycle strobe: rx_data holds a new byte
//  duty_r      out  8  red duty value
//  duty_g      out  8  green duty value
//  duty_b      out  8  blue duty value
//  frame_ok    out  1  one-cycle strobe: valid frame executed
//  frame_err   out  1  one-cycle strobe: frame rejected (checksum/bad cmd/timeout)
//  err_count   out  8  saturating count of frame_err strobes
//  busy        out  1  1 while a frame is partially received (state != S_IDLE)
// BEHAVIOUR
//  Frame: HDR=0xA5, CMD, VAL, CHK; CHK must equal CMD ^ VAL.
//  CMD: 0x00 clear all (VAL ignored); 0x01 R=VAL; 0x02 G=VAL; 0x03 B=VAL; 0x04 R=G=B=VAL.
//   Any other CMD -> frame_err, duties unchanged.
//  Reset (rst_n=0 at posedge): state S_IDLE, duty_r/g/b=0, frame_ok=0, frame_err=0,
//   err_count=0, timer=0, busy=0. Reset mid-frame discards the partial frame, no strobe.
//  FSM (advances only on rx_done=1 unless noted):
//   S_IDLE : byte==0xA5 -> S_CMD; any other byte ignored silently (no error).
//   S_CMD  : latch CMD -> S_VAL.
//   S_VAL  : latch VAL -> S_CHK.
//   S_CHK  : compare; valid -> apply, frame_ok; invalid -> frame_err; always -> S_IDLE.
//  0xA5 received in S_CMD/S_VAL/S_CHK is ordinary payload, never a resync.
//  Latency: CHK strobe at edge N -> new duty values and frame_ok/frame_err visible
//   after edge N+1 (registered, one cycle). Strobes are exactly one cycle wide.
//  Timer: cleared on every accepted byte and in S_IDLE; increments each clk otherwise.
//   timer == TIMEOUT_CYCLES-1 with no rx_done that cycle -> frame_err, S_IDLE.
//   Simultaneous rx_done and timeout expiry: byte wins, no timeout.
//  err_count: +1 on each frame_err; holds at 255 (no wrap).
//  Back-to-back frames: a HDR byte in the cycle after CHK is accepted (S_IDLE).
//  rx_data is ignored whenever rx_done=0.
// STRUCTURE
//  uart_led_cmd_defs.vh: HDR_BYTE, CMD_CLR/CMD_R/CMD_G/CMD_B/CMD_ALL, state encodings.
//  Sub-module frame_timer (CNT_W, TIMEOUT_CYCLES): clear/run inputs, expire strobe.
//  FSM, payload latches, duty regs and err counter live in this module.
//  Instantiated in top: rx_data/rx_done from uart_rx; duty_* to the PWM/rgb driver.
// TESTING
//  T1 reset: hold rst_n=0 3 clks -> duties 0x00, err_count 0, busy 0, no strobes.
//  T2 bytes A5 01 80 81 -> duty_r=0x80, g/b unchanged, frame_ok one cycle after CHK.
//  T3 bytes A5 04 3C 38 then A5 00 00 00 -> all duties 0x3C then all 0x00, two frame_ok.
//  T4 bytes A5 02 10 FF -> frame_err, duty_g unchanged, err_count=1; A5 07 00 07 -> err=2.
//  T5 A5 01 then silence TIMEOUT_CYCLES clks -> frame_err, busy=0; rx_done on expiry
//   cycle -> no timeout, frame continues.
//  T6 stray 55 12, A5 03 A5 A6 -> no err for strays, duty_b=0xA5; 260 bad frames ->
//   err_count stays 255; rst_n=0 after A5 01 -> S_IDLE, no strobe.

Source files
------------

// File: rtl/uart_led_cmd_ctrl_pkg.sv
// Shared constants and bundle types for the UART LED command sequencer.
// Frame layout: HDR, CMD, VAL, CHK with CHK = CMD ^ VAL.
package uart_led_cmd_ctrl_pkg;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  localparam logic [7:0] CMD_CLR = 8'h00;
  localparam logic [7:0] CMD_R   = 8'h01;
  localparam logic [7:0] CMD_G   = 8'h02;
  localparam logic [7:0] CMD_B   = 8'h03;
  localparam logic [7:0] CMD_ALL = 8'h04;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_VAL  = 2'd2,
    S_CHK  = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } duty_t;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] val;
  } payload_t;

endpackage

// File: rtl/uart_led_cmd_ctrl_frame_timer.sv
// Inter-byte idle timer; expire pulses when the idle budget runs out.
// clear has priority over run, so a byte on the last cycle wins.
module uart_led_cmd_ctrl_frame_timer #(
  parameter int CNT_W          = 15,
  parameter int TIMEOUT_CYCLES = 24000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && count != LAST) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = run && !clear && (count == LAST);

endmodule

// File: rtl/uart_led_cmd_ctrl.sv
// Assembles 4-byte command frames from uart_rx and drives RGB duty registers.
// Reports per-frame ok/err strobes and a saturating error count.
module uart_led_cmd_ctrl
  import uart_led_cmd_ctrl_pkg::*;
#(
  parameter int CLOCK_FREQ     = 12000000,
  parameter int TIMEOUT_CYCLES = CLOCK_FREQ / 500,
  parameter int CNT_W          = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] duty_r,
  output logic [7:0] duty_g,
  output logic [7:0] duty_b,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [7:0] err_count,
  output logic       busy
);

  state_t   state, state_n;
  payload_t pay_q, pay_n;
  duty_t    duty_q, duty_n;
  logic     ok_n, err_n;
  logic     tmr_clear, tmr_run, expire;

  assign tmr_clear = rx_done || (state == S_IDLE);
  assign tmr_run   = (state != S_IDLE);

  uart_led_cmd_ctrl_frame_timer #(
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tmr_clear),
    .run   (tmr_run),
    .expire(expire)
  );

  always_comb begin
    state_n = state;
    pay_n   = pay_q;
    duty_n  = duty_q;
    ok_n    = 1'b0;
    err_n   = 1'b0;
    if (expire) begin
      state_n = S_IDLE;
      err_n   = 1'b1;
    end else if (rx_done) begin
      unique case (state)
        S_IDLE: begin
          if (rx_data == HDR_BYTE) state_n = S_CMD;
        end
        S_CMD: begin
          pay_n.cmd = rx_data;
          state_n   = S_VAL;
        end
        S_VAL: begin
          pay_n.val = rx_data;
          state_n   = S_CHK;
        end
        S_CHK: begin
          state_n = S_IDLE;
          if (rx_data != (pay_q.cmd ^ pay_q.val)) begin
            err_n = 1'b1;
          end else begin
            ok_n = 1'b1;
            case (pay_q.cmd)
              CMD_CLR: duty_n   = '0;
              CMD_R:   duty_n.r = pay_q.val;
              CMD_G:   duty_n.g = pay_q.val;
              CMD_B:   duty_n.b = pay_q.val;
              CMD_ALL: duty_n   = {3{pay_q.val}};
              default: begin
                ok_n  = 1'b0;
                err_n = 1'b1;
              end
            endcase
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pay_q     <= '0;
      duty_q    <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      pay_q     <= pay_n;
      duty_q    <= duty_n;
      frame_ok  <= ok_n;
      frame_err <= err_n;
      if (err_n && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  assign duty_r = duty_q.r;
  assign duty_g = duty_q.g;
  assign duty_b = duty_q.b;
  assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_uart_led_cmd_ctrl.sv
// Self-checking bench for uart_led_cmd_ctrl against a byte-level frame model.
// Short timeout parameter keeps idle-expiry scenarios fast.
module tb_uart_led_cmd_ctrl;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] duty_r, duty_g, duty_b, err_count;
  logic       frame_ok, frame_err, busy;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit         in_frame;
  byte        got[$];
  int         idle;
  logic [7:0] m_r, m_g, m_b, m_errcnt;
  bit         m_ok, m_err;
  int         exp_ok_total, exp_err_total;
  int         ok_seen, err_seen;

  uart_led_cmd_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (15)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .duty_r   (duty_r),
    .duty_g   (duty_g),
    .duty_b   (duty_b),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_count(err_count),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: sim time exceeded, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic model_err();
    m_err = 1'b1;
    exp_err_total++;
    if (m_errcnt != 8'hFF) m_errcnt++;
  endtask

  task automatic model_frame();
    logic [7:0] cmd, val, chk;
    cmd = got[0];
    val = got[1];
    chk = got[2];
    if (chk != (cmd ^ val) || cmd > 8'h04) begin
      model_err();
    end else begin
      if (cmd == 8'h00) {m_r, m_g, m_b} = 24'h0;
      if (cmd == 8'h01) m_r = val;
      if (cmd == 8'h02) m_g = val;
      if (cmd == 8'h03) m_b = val;
      if (cmd == 8'h04) {m_r, m_g, m_b} = {val, val, val};
      m_ok = 1'b1;
      exp_ok_total++;
    end
  endtask

  task automatic model_step(input logic d, input logic [7:0] b);
    m_ok  = 1'b0;
    m_err = 1'b0;
    if (!rst_n) begin
      in_frame = 1'b0;
      got.delete();
      idle = 0;
      {m_r, m_g, m_b, m_errcnt} = 32'h0;
      exp_ok_total = 0;
      exp_err_total = 0;
      ok_seen = 0;
      err_seen = 0;
    end else if (in_frame) begin
      if (d) begin
        got.push_back(b);
        idle = 0;
        if (got.size() == 3) begin
          in_frame = 1'b0;
          model_frame();
        end
      end else begin
        idle++;
        if (idle >= TO) begin
          in_frame = 1'b0;
          model_err();
        end
      end
    end else if (d && b == 8'hA5) begin
      in_frame = 1'b1;
      got.delete();
      idle = 0;
    end
  endtask

  task automatic tick(input logic d, input logic [7:0] b);
    rx_done = d;
    rx_data = b;
    @(posedge clk);
    #1;
    model_step(d, b);
    if (rst_n) begin
      if (frame_ok === 1'b1) ok_seen++;
      if (frame_err === 1'b1) err_seen++;
    end
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) tick(1'b0, 8'($urandom));
    tick(1'b1, b);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] v,
                            input logic [7:0] k);
    send(8'hA5, $urandom_range(0, 3));
    send(c, $urandom_range(0, 3));
    send(v, $urandom_range(0, 3));
    send(k, $urandom_range(0, 3));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick(1'($urandom), 8'hA5);
    rst_n = 1'b1;
    n_tests++;
    if ({duty_r, duty_g, duty_b} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_duty: got %h want 000000", {duty_r, duty_g, duty_b});
    end
    n_tests++;
    if (err_count !== 8'h00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cnt_busy: got %h/%b want 00/0", err_count, busy);
    end
    n_tests++;
    if (frame_ok !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b%b want 00", frame_ok, frame_err);
    end
  endtask

  task automatic test_single();
    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h80, 0);
    send(8'h81, 0);
    n_tests++;
    if (frame_ok !== 1'b1 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_strobe: got ok=%b err=%b want 1/0", frame_ok, frame_err);
    end
    n_tests++;
    if ({duty_r, duty_g, duty_b} !== 24'h800000) begin
      n_fail++;
      $display("FAIL single_duty: got %h want 800000", {duty_r, duty_g, duty_b});
    end
    tick(1'b0, 8'h00);
    n_tests++;
    if (frame_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL single_width: got %b want 0", frame_ok);
    end
  endtask

  task automatic test_all_clear();
    send_frame(8'h04, 8'h3C, 8'h38);
    n_tests++;
    if ({duty_r, duty_g, duty_b} !== 24'h3C3C3C || frame_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL all_set: got %h ok=%b want 3c3c3c ok=1",
               {duty_r, duty_g, duty_b}, frame_ok);
    end
    send_frame(8'h00, 8'h00, 8'h00);
    n_tests++;
    if ({duty_r, duty_g, duty_b} !== 24'h0 || frame_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL all_clear: got %h ok=%b want 000000 ok=1",
               {duty_r, duty_g, duty_b}, frame_ok);
    end
  endtask

  task automatic test_bad();
    send_frame(8'h02, 8'h77, 8'h75);
    send_frame(8'h02, 8'h10, 8'hFF);
    n_tests++;
    if (frame_err !== 1'b1 || frame_ok !== 1'b0 || duty_g !== 8'h77) begin
      n_fail++;
      $display("FAIL bad_chk: got err=%b ok=%b g=%h want 1/0/77",
               frame_err, frame_ok, duty_g);
    end
    n_tests++;
    if (err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL bad_chk_cnt: got %0d want 1", err_count);
    end
    send_frame(8'h07, 8'h00, 8'h07);
    n_tests++;
    if (frame_err !== 1'b1 || err_count !== 8'd2 || duty_g !== 8'h77) begin
      n_fail++;
      $display("FAIL bad_cmd: got err=%b cnt=%0d g=%h want 1/2/77",
               frame_err, err_count, duty_g);
    end
  endtask

  task automatic test_timeout();
    int errs0;
    errs0 = err_seen;
    send(8'hA5, 0);
    send(8'h01, 0);
    repeat (TO - 1) tick(1'b0, 8'h00);
    n_tests++;
    if (frame_err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early: got err=%b busy=%b want 0/1", frame_err, busy);
    end
    tick(1'b0, 8'h00);
    n_tests++;
    if (frame_err !== 1'b1 || busy !== 1'b0 || err_seen != errs0 + 1) begin
      n_fail++;
      $display("FAIL timeout_fire: got err=%b busy=%b want 1/0", frame_err, busy);
    end
    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h80, TO - 1);
    n_tests++;
    if (frame_err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_race: got err=%b busy=%b want 0/1", frame_err, busy);
    end
    send(8'h81, TO - 1);
    n_tests++;
    if (frame_ok !== 1'b1 || duty_r !== 8'h80) begin
      n_fail++;
      $display("FAIL timeout_race_done: got ok=%b r=%h want 1/80", frame_ok, duty_r);
    end
  endtask

  task automatic test_stray();
    int errs0;
    errs0 = err_seen;
    send(8'h55, 1);
    send(8'h12, 2);
    n_tests++;
    if (busy !== 1'b0 || err_seen != errs0) begin
      n_fail++;
      $display("FAIL stray: got busy=%b errs=%0d want 0/%0d", busy, err_seen, errs0);
    end
    send(8'hA5, 0);
    send(8'h03, 0);
    send(8'hA5, 0);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hdr_payload: got busy=%b want 1", busy);
    end
    send(8'hA6, 0);
    n_tests++;
    if (duty_b !== 8'hA5 || frame_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL hdr_payload_b: got b=%h ok=%b want a5/1", duty_b, frame_ok);
    end
  endtask

  task automatic test_back_to_back();
    int oks0;
    oks0 = ok_seen;
    for (int i = 0; i < 4; i++) begin
      send(8'hA5, 0);
      send(8'h01, 0);
      send(8'(i * 16), 0);
      send(8'(8'h01 ^ 8'(i * 16)), 0);
    end
    n_tests++;
    if (ok_seen != oks0 + 4 || duty_r !== 8'h30) begin
      n_fail++;
      $display("FAIL back_to_back: got oks=%0d r=%h want %0d/30",
               ok_seen - oks0, duty_r, 4);
    end
  endtask

  task automatic test_random();
    logic [7:0] c, v, k;
    for (int f = 0; f < 200; f++) begin
      c = 8'($urandom_range(0, 6));
      v = 8'($urandom);
      k = ($urandom_range(0, 4) == 0) ? 8'($urandom) : (c ^ v);
      send(($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hA5,
           $urandom_range(0, 2));
      send(c, ($urandom_range(0, 19) == 0) ? $urandom_range(TO - 2, TO + 2)
                                           : $urandom_range(0, 2));
      send(v, $urandom_range(0, 2));
      send(k, ($urandom_range(0, 19) == 0) ? $urandom_range(TO - 2, TO + 2)
                                           : $urandom_range(0, 2));
      n_tests++;
      if ({duty_r, duty_g, duty_b} !== {m_r, m_g, m_b} || err_count !== m_errcnt ||
          frame_ok !== m_ok || frame_err !== m_err || busy !== in_frame) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h %h %b%b%b want %h %h %b%b%b", f,
                 {duty_r, duty_g, duty_b}, err_count, frame_ok, frame_err, busy,
                 {m_r, m_g, m_b}, m_errcnt, m_ok, m_err, in_frame);
      end
    end
    n_tests++;
    if (ok_seen != exp_ok_total || err_seen != exp_err_total) begin
      n_fail++;
      $display("FAIL strobe_counts: got ok=%0d err=%0d want ok=%0d err=%0d",
               ok_seen, err_seen, exp_ok_total, exp_err_total);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 260; i++) begin
      send(8'hA5, 0);
      send(8'h07, 0);
      send(8'h00, 0);
      send(8'h07, 0);
    end
    n_tests++;
    if (err_count !== 8'hFF || m_errcnt != 8'hFF) begin
      n_fail++;
      $display("FAIL saturate: got %0d want 255", err_count);
    end
    n_tests++;
    if (frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate_strobe: got %b want 1", frame_err);
    end
  endtask

  task automatic test_reset_mid();
    send(8'hA5, 0);
    send(8'h01, 0);
    rst_n = 1'b0;
    tick(1'b0, 8'h00);
    rst_n = 1'b1;
    n_tests++;
    if (busy !== 1'b0 || frame_ok !== 1'b0 || frame_err !== 1'b0 ||
        err_count !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b ok=%b err=%b cnt=%0d want 0/0/0/0",
               busy, frame_ok, frame_err, err_count);
    end
    send(8'h80, 0);
    send(8'h81, 0);
    n_tests++;
    if (duty_r !== 8'h00 || frame_ok !== 1'b0 || ok_seen != 0) begin
      n_fail++;
      $display("FAIL reset_mid_discard: got r=%h ok=%b want 00/0", duty_r, frame_ok);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_clear();
    test_bad();
    test_timeout();
    test_stray();
    test_back_to_back();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
